rv32i_mem_arbiter: RTL and testbench
====================================

# rv32i_mem_arbiter

Two-master arbiter that shares one synchronous single-port memory between the rv32i CPU bus (master 0) and a secondary bus master (master 1: program loader / debug / DMA). It sits between the masters and the memory, serialises their read and write transactions, and applies round-robin priority. It also returns read data to the requesting master with a valid strobe. One transaction is in flight at a time; the memory sees exactly the address, data, mask and strobe the granted master presented.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- RD_LATENCY, 1, cycles from the mem_rd-high cycle to mem_data_in valid; legal range 1..7
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- mN_req  in  1  request from master N (N = 0, 1); held until mN_gnt
- mN_wr  in  1  1 = write, 0 = read; qualified by mN_req
- mN_addr  in  ADDR_W  transaction address
- mN_wdata  in  DATA_W  write data
- mN_wmask  in  DATA_W/8  byte write enables
- mN_gnt  out  1  one-cycle pulse; request accepted, memory strobe driven this cycle
- mN_rdata  out  DATA_W  read data; valid only while mN_rvalid
- mN_rvalid  out  1  one-cycle pulse, read data returned
- mem_addr  out  ADDR_W  memory address (registered)
- mem_data_out  out  DATA_W  memory write data (registered)
- mem_wr_mask  out  DATA_W/8  byte enables (registered)
- mem_rd  out  1  read strobe, one cycle
- mem_wr  out  1  write strobe, one cycle
- mem_data_in  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, WRITE, READ_WAIT, READ_DONE.
- IDLE: sample m0_req/m1_req. If none, stay. If one, select it. If both, select the master other than last_gnt. On selection, register addr/wdata/wmask into mem_* and pulse the selected mN_gnt next cycle. Enter WRITE (mem_wr=1) or READ_WAIT (mem_rd=1, load wait counter with RD_LATENCY). Update last_gnt.
- WRITE: strobe cycle only; return to IDLE.
- READ_WAIT: decrement counter each cycle. When it reaches 0, mem_data_in is valid: capture it into the selected master's rdata and go to READ_DONE.
- READ_DONE: pulse mN_rvalid for the owning master; return to IDLE. IDLE requests are sampled in this same cycle's successor.
- Counter width is 3 bits; RD_LATENCY outside 1..7 is a parameter error (elaboration assertion).
- mem_rd and mem_wr are never high together. mem_* hold their last value when not strobed. The rdata of a non-owning master is unchanged.
- Master contract: keep req and its qualifiers stable until gnt. Drop req on the edge where gnt=1. A req still high afterwards is a new request. A req withdrawn before gnt is simply not served.
- Dropping req after gnt does not cancel a read: rvalid is still delivered.
- Reset values: state=IDLE, last_gnt=1 (master 0 wins the first tie), all outputs 0, counter 0. Reset mid-read discards the transaction and no rvalid is produced.

## Timing
- Cycle 0: req sampled in IDLE.
- Cycle 1: mem strobe and mN_gnt.
- Write occupies cycles 1..1. The arbiter is IDLE in cycle 2, so the next strobe is in cycle 3 at the earliest.
- Read: mem_data_in valid in cycle 1+RD_LATENCY, mN_rvalid/mN_rdata in cycle 2+RD_LATENCY. The earliest next strobe is in cycle 4+RD_LATENCY.
- No combinational path from any input to any output.
- Sustained contention produces strictly alternating grants.

## Structure
- Package rv32i_bus_pkg: FSM state enum, master-id constants (MASTER_CPU=0, MASTER_AUX=1), and the RD_LATENCY range constants.
- Sub-module rr_pick2: combinational round-robin selector (inputs: req[1:0], last; outputs: valid, sel). Instantiated once inside the arbiter.

## Test plan
- Single read: m0 reads 0x0000_0010 with memory word 0xDEADBEEF and RD_LATENCY=1 → m0_gnt in cycle 1, mem_rd in cycle 1 only, m0_rvalid with m0_rdata=0xDEADBEEF in cycle 3, m1 outputs untouched.
- Single write: m1 writes 0x1234_5678 to 0x20 with mask 4'b0011 → mem_wr=1, mem_addr=0x20, mem_wr_mask=0011 in cycle 1, m1_gnt in cycle 1, no rvalid pulses.
- Simultaneous requests after reset: m0 and m1 both request → first grant goes to m0 and second to m1. Holding both continuously for 6 transactions gives the grant sequence 0,1,0,1,0,1.
- Contention during a busy read: m1 requests in cycle 2 while m0's read is in flight (RD_LATENCY=3) → no m1 strobe before m0_rvalid (cycle 5); m1 strobe in cycle 7.
- Reset mid-read: assert reset in cycle 2 of an m0 read → all outputs 0 immediately, no m0_rvalid. After release, an m0 request is served normally.
- Withdrawn request: m1_req is high for one IDLE-less cycle during a write and then dropped before gnt → no m1_gnt, no strobe for m1.

Source files
------------

// File: rtl/rv32i_bus_pkg.sv
// rv32i_bus_pkg
// Shared definitions for the two-master memory arbiter: FSM state encoding,
// master identifiers and the legal read-latency range of the memory.
// No ports (package).
package rv32i_bus_pkg;

  // Arbiter FSM state encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE      = 2'd0;
  localparam arb_state_t ST_WRITE     = 2'd1;
  localparam arb_state_t ST_READ_WAIT = 2'd2;
  localparam arb_state_t ST_READ_DONE = 2'd3;

  // Master identifiers, also used as the round-robin "last granted" value
  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

  // Read latency range supported by the 3-bit wait counter
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/rv32i_mem_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin selector.
// Ports:
//   req   [1:0] in  request vector, bit N = master N
//   last        in  master granted most recently
//   valid       out at least one request present
//   sel         out selected master (meaningful only when valid)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  always_comb begin
    valid = |req;
    // On a tie the master that did not win last time goes next
    if (req == 2'b11) begin
      sel = ~last;
    end else begin
      sel = req[1];
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares one synchronous single-port memory between the CPU bus (master 0)
// and an auxiliary master (master 1). One transaction at a time, round-robin
// on contention, all outputs registered.
// States:
//   IDLE      | sample requests, launch the selected transaction
//   WRITE     | write strobe cycle
//   READ_WAIT | read strobe issued, counting down the memory latency
//   READ_DONE | read data returned to the owning master (rvalid pulse)
// Ports:
//   clk, reset                 clock, async active-high reset
//   mN_req/wr/addr/wdata/wmask master N request and qualifiers
//   mN_gnt                     one-cycle accept pulse (same cycle as strobe)
//   mN_rdata/mN_rvalid         read data return
//   mem_addr/data_out/wr_mask  registered memory controls, held between strobes
//   mem_rd/mem_wr              one-cycle memory strobes
//   mem_data_in                memory read data
module rv32i_mem_arbiter
  import rv32i_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_wr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_gnt,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic                m1_req,
  input  logic                m1_wr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_gnt,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic [DATA_W/8-1:0] mem_wr_mask,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic [DATA_W-1:0]   mem_data_in
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] RD_LAT_LD = CNT_W'(RD_LATENCY);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
    $error("rv32i_mem_arbiter: RD_LATENCY must be in 1..7");
  end

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;
  logic [MASK_W-1:0] mem_wr_mask_q, mem_wr_mask_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pick_valid;
  logic pick_sel;
  logic sel_wr;

  rr_pick2 u_rr_pick2 (
    .req   ({m1_req, m0_req}),
    .last  (last_gnt_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  assign sel_wr = pick_sel ? m1_wr : m0_wr;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_gnt_d     = last_gnt_q;
    owner_d        = owner_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    mem_wr_mask_d  = mem_wr_mask_q;
    mem_rd_d       = 1'b0;
    mem_wr_d       = 1'b0;
    gnt_d          = 2'b00;
    rvalid_d       = 2'b00;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d        = pick_sel;
          last_gnt_d     = pick_sel;
          gnt_d          = pick_sel ? 2'b10 : 2'b01;
          mem_addr_d     = pick_sel ? m1_addr  : m0_addr;
          mem_data_out_d = pick_sel ? m1_wdata : m0_wdata;
          mem_wr_mask_d  = pick_sel ? m1_wmask : m0_wmask;
          if (sel_wr) begin
            mem_wr_d = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            mem_rd_d = 1'b1;
            cnt_d    = RD_LAT_LD;
            state_d  = ST_READ_WAIT;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ_WAIT: begin
        // Counter hits zero in the cycle the memory presents its data
        if (cnt_q == '0) begin
          if (owner_q == MASTER_AUX) begin
            rdata1_d = mem_data_in;
            rvalid_d = 2'b10;
          end else begin
            rdata0_d = mem_data_in;
            rvalid_d = 2'b01;
          end
          state_d = ST_READ_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READ_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      last_gnt_q     <= MASTER_AUX;
      owner_q        <= MASTER_CPU;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      mem_wr_mask_q  <= '0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      gnt_q          <= 2'b00;
      rvalid_q       <= 2'b00;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_gnt_q     <= last_gnt_d;
      owner_q        <= owner_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      mem_wr_mask_q  <= mem_wr_mask_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      gnt_q          <= gnt_d;
      rvalid_q       <= rvalid_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
    end
  end

  assign m0_gnt       = gnt_q[0];
  assign m1_gnt       = gnt_q[1];
  assign m0_rvalid    = rvalid_q[0];
  assign m1_rvalid    = rvalid_q[1];
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_wr_mask  = mem_wr_mask_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter
// Directed bench for rv32i_mem_arbiter. Two instances share stimulus:
// dut_a with RD_LATENCY=1 and dut_b with RD_LATENCY=3. Each has its own
// memory model that drives valid data only in the cycle RD_LATENCY after
// the read strobe, and a poison value otherwise.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;

  logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_rd, a_mem_wr;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_data_out, a_mem_data_in;
  logic [3:0]  a_mem_wr_mask;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_rd, b_mem_wr;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_data_out, b_mem_data_in;
  logic [3:0]  b_mem_wr_mask;

  logic [7:0]  a_rd_pipe, b_rd_pipe;

  int n_chk = 0;
  int n_bad = 0;
  int rv_cyc, st_cyc, cnt, dbl;
  logic [31:0] seen_data, seen_addr;
  int seq[$];

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_gnt(a_m0_gnt), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_gnt(a_m1_gnt), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
    .mem_addr(a_mem_addr), .mem_data_out(a_mem_data_out), .mem_wr_mask(a_mem_wr_mask),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_data_in(a_mem_data_in)
  );

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
    .mem_addr(b_mem_addr), .mem_data_out(b_mem_data_out), .mem_wr_mask(b_mem_wr_mask),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_data_in(b_mem_data_in)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_pipe <= '0;
      b_rd_pipe <= '0;
    end else begin
      a_rd_pipe <= {a_rd_pipe[6:0], a_mem_rd};
      b_rd_pipe <= {b_rd_pipe[6:0], b_mem_rd};
    end
  end

  assign a_mem_data_in = a_rd_pipe[0] ? mem_word(a_mem_addr) : 32'hBAD0_BAD0;
  assign b_mem_data_in = b_rd_pipe[2] ? mem_word(b_mem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
  endtask

  // Leaves the bench #1 after an edge with reset low: the next cycle is cycle 0
  task automatic do_reset;
    reset = 1;
    clear_inputs();
    repeat (2) tick();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    #2;
    // Reset values
    chk("rst_strobes", {26'd0, a_mem_rd, a_mem_wr, a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid}, 32'd0);
    chk("rst_addr", a_mem_addr, 32'd0);
    chk("rst_wdata", a_mem_data_out, 32'd0);
    chk("rst_mask", {28'd0, a_mem_wr_mask}, 32'd0);
    chk("rst_rdata0", a_m0_rdata, 32'd0);

    // Single read, RD_LATENCY=1
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h10;
    tick();  // cycle 1
    chk("rd1_gnt", {31'd0, a_m0_gnt}, 32'd1);
    chk("rd1_memrd", {31'd0, a_mem_rd}, 32'd1);
    chk("rd1_memwr", {31'd0, a_mem_wr}, 32'd0);
    chk("rd1_addr", a_mem_addr, 32'h10);
    m0_req = 0;
    tick();  // cycle 2
    chk("rd2_memrd", {31'd0, a_mem_rd}, 32'd0);
    chk("rd2_gnt", {31'd0, a_m0_gnt}, 32'd0);
    chk("rd2_rvalid", {31'd0, a_m0_rvalid}, 32'd0);
    tick();  // cycle 3
    chk("rd3_rvalid", {31'd0, a_m0_rvalid}, 32'd1);
    chk("rd3_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    chk("rd3_m1", {30'd0, a_m1_gnt, a_m1_rvalid}, 32'd0);
    chk("rd3_m1_rdata", a_m1_rdata, 32'd0);
    tick();  // cycle 4
    chk("rd4_rvalid", {31'd0, a_m0_rvalid}, 32'd0);

    // Single write from m1
    do_reset();
    m1_req = 1; m1_wr = 1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wmask = 4'b0011;
    tick();  // cycle 1
    chk("wr_memwr", {31'd0, a_mem_wr}, 32'd1);
    chk("wr_memrd", {31'd0, a_mem_rd}, 32'd0);
    chk("wr_addr", a_mem_addr, 32'h20);
    chk("wr_data", a_mem_data_out, 32'h1234_5678);
    chk("wr_mask", {28'd0, a_mem_wr_mask}, 32'h3);
    chk("wr_gnt", {30'd0, a_m1_gnt, a_m0_gnt}, 32'h2);
    m1_req = 0;
    cnt = 0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (a_m0_rvalid || a_m1_rvalid) cnt++;
      if (c == 2) begin
        chk("wr_strobe_end", {31'd0, a_mem_wr}, 32'd0);
        chk("wr_addr_hold", a_mem_addr, 32'h20);
      end
    end
    chk("wr_no_rvalid", cnt, 32'd0);

    // Simultaneous, sustained contention (writes)
    do_reset();
    m0_wr = 1; m0_addr = 32'h100; m0_wdata = 32'hAAAA_0000; m0_wmask = 4'hF;
    m1_wr = 1; m1_addr = 32'h200; m1_wdata = 32'hBBBB_0000; m1_wmask = 4'hF;
    m0_req = 1; m1_req = 1;
    seq.delete();
    dbl = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (a_m0_gnt && a_m1_gnt) dbl++;
      if (a_m0_gnt) begin
        seq.push_back(0);
        chk("rr_addr0", a_mem_addr, 32'h100);
      end else if (a_m1_gnt) begin
        seq.push_back(1);
        chk("rr_addr1", a_mem_addr, 32'h200);
      end
    end
    chk("rr_double", dbl, 32'd0);
    chk("rr_count", seq.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < seq.size()) chk("rr_seq", seq[i], i % 2);
    end
    clear_inputs();

    // Contention during a busy read, RD_LATENCY=3
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h40;
    tick();  // cycle 1
    chk("busy_gnt0", {31'd0, b_m0_gnt}, 32'd1);
    chk("busy_memrd", {31'd0, b_mem_rd}, 32'd1);
    m0_req = 0;
    tick();  // cycle 2
    m1_req = 1; m1_wr = 1; m1_addr = 32'h80; m1_wdata = 32'h55; m1_wmask = 4'hF;
    rv_cyc = 99; st_cyc = 99; seen_data = 0; seen_addr = 0;
    for (int c = 2; c <= 10; c++) begin
      if (c > 2) tick();
      if (b_m0_rvalid && rv_cyc == 99) begin
        rv_cyc = c;
        seen_data = b_m0_rdata;
      end
      if ((b_mem_rd || b_mem_wr || b_m1_gnt) && st_cyc == 99) begin
        st_cyc = c;
        seen_addr = b_mem_addr;
      end
      if (b_m1_gnt) m1_req = 0;
    end
    chk("busy_rvalid_cyc", rv_cyc, 32'd5);
    chk("busy_rdata", seen_data, 32'h0040_C0DE);
    chk("busy_m1_strobe_cyc", st_cyc, 32'd7);
    chk("busy_m1_addr", seen_addr, 32'h80);
    clear_inputs();

    // Reset in the middle of a read, RD_LATENCY=3
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h40;
    tick();  // cycle 1
    m0_req = 0;
    tick();  // cycle 2
    reset = 1;
    #1;
    chk("mid_rst_strobes", {28'd0, b_mem_rd, b_mem_wr, b_m0_gnt, b_m0_rvalid}, 32'd0);
    chk("mid_rst_addr", b_mem_addr, 32'd0);
    chk("mid_rst_rdata", b_m0_rdata, 32'd0);
    do_reset();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (b_m0_rvalid) cnt++;
    end
    chk("mid_rst_no_rvalid", cnt, 32'd0);
    m0_req = 1; m0_wr = 0; m0_addr = 32'h44;
    tick();  // cycle 1
    chk("post_rst_gnt", {31'd0, b_m0_gnt}, 32'd1);
    m0_req = 0;
    rv_cyc = 99; seen_data = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (b_m0_rvalid && rv_cyc == 99) begin
        rv_cyc = c;
        seen_data = b_m0_rdata;
      end
    end
    chk("post_rst_rvalid_cyc", rv_cyc, 32'd5);
    chk("post_rst_rdata", seen_data, 32'h0044_C0DE);

    // Withdrawn request during a write
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 32'h30; m0_wdata = 32'h77; m0_wmask = 4'hF;
    tick();  // cycle 1
    chk("wd_gnt0", {31'd0, a_m0_gnt}, 32'd1);
    m0_req = 0;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h90;
    tick();  // cycle 2
    m1_req = 0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_m1_gnt || a_mem_rd || a_mem_wr) cnt++;
    end
    chk("wd_no_m1", cnt, 32'd0);
    chk("wd_addr_hold", a_mem_addr, 32'h30);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
